// File: rtl/result_arbiter.sv
// result_arbiter: round-robin arbiter that lets NUM_ENG calculating engines
// share one result bus and turns each granted result word into a frame-RAM
// write. It also keeps a running pixel count with frame-wrap detection and
// raises a sticky flag when a coordinate falls outside the frame.
//
// state | meaning
// IDLE  | no transaction in flight, waiting for any eng_req
// GRANT | one eng_ack bit high; eng_word captured at the closing edge
// WRITE | wr_en high (unless out of range); next winner may be granted
module result_arbiter #(
  parameter int NUM_ENG = 12,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480
) (
  input  logic               clk_iCLK,
  input  logic               iRST_N,
  input  logic [NUM_ENG-1:0] eng_req,
  input  logic [26:0]        eng_word,
  input  logic               frame_clr,
  output logic [NUM_ENG-1:0] eng_ack,
  output logic               wr_en,
  output logic [18:0]        wr_addr,
  output logic [7:0]         wr_data,
  output logic [18:0]        pix_count,
  output logic               frame_done,
  output logic               err_oob
);

  typedef enum logic [1:0] {IDLE, GRANT, WRITE} state_t;

  localparam int                 IW         = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam logic [NUM_ENG-1:0] ONE        = NUM_ENG'(1);
  localparam logic [IW-1:0]      LAST_RST   = IW'(NUM_ENG - 1);
  localparam logic [18:0]        FRAME_LAST = 19'(H_RES * V_RES - 1);

  state_t             state;
  logic [IW-1:0]      last_q;
  logic [IW-1:0]      win_idx;
  logic               win_vld;
  logic [NUM_ENG-1:0] req_m;
  logic [9:0]         wx;
  logic [8:0]         wy;
  logic [18:0]        addr_calc;
  logic               oob;

  assign wx = eng_word[26:17];
  assign wy = eng_word[16:8];

  // y*640 built from shifts, kept at the full 19-bit width
  assign addr_calc = {9'd0, wx} + ({10'd0, wy} << 9) + ({10'd0, wy} << 7);
  assign oob       = ({22'd0, wx} >= 32'(H_RES)) || ({23'd0, wy} >= 32'(V_RES));

  // The engine just served is masked while its write is on the bus, so a
  // lingering request cannot win twice in a row.
  assign req_m = (state == WRITE) ? (eng_req & ~(ONE << last_q)) : eng_req;

  // Round-robin search starting one past the last-served engine, wrapping.
  always_comb begin
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = 1; i <= NUM_ENG; i++) begin
      idx = (int'(last_q) + i) % NUM_ENG;
      if (!win_vld && req_m[idx]) begin
        win_vld = 1'b1;
        win_idx = idx[IW-1:0];
      end
    end
  end

  // Arbitration FSM, write strobe, pixel counter and error flag.
  always_ff @(posedge clk_iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= IDLE;
      last_q     <= LAST_RST;
      eng_ack    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      pix_count  <= '0;
      frame_done <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      eng_ack    <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        IDLE, WRITE: begin
          if (win_vld) begin
            eng_ack <= ONE << win_idx;
            last_q  <= win_idx;
            state   <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          wr_addr <= addr_calc;
          wr_data <= eng_word[7:0];
          if (oob) err_oob <= 1'b1;
          else     wr_en   <= 1'b1;
          state <= WRITE;
        end
        default: state <= IDLE;
      endcase

      // A clear wins over a coincident write: the write still happens on the
      // bus but is not counted and cannot produce frame_done.
      if (frame_clr) begin
        pix_count <= '0;
        err_oob   <= 1'b0;
      end else if (wr_en) begin
        if (pix_count == FRAME_LAST) begin
          pix_count  <= '0;
          frame_done <= 1'b1;
        end else begin
          pix_count <= pix_count + 19'd1;
        end
      end
    end
  end

endmodule

// File: doc/result_arbiter.md
RESULT_ARBITER -- requirements
Module: result_arbiter

Interface
REQ-001 Parameter NUM_ENG, default 12: number of calculating engines sharing the result bus.
REQ-002 Parameter H_RES, default 640: frame width in pixels.
REQ-003 Parameter V_RES, default 480: frame height in pixels.
REQ-004 clk_iCLK  in  1  single engine-domain clock; all logic SHALL be clocked on its rising edge.
REQ-005 iRST_N  in  1  asynchronous, active-low reset.
REQ-006 eng_req  in  NUM_ENG  per-engine service request, one bit per engine, level.
REQ-007 eng_word  in  27  shared result bus: [26:17] x, [16:8] y, [7:0] iteration/colour data; driven by the acknowledged engine.
REQ-008 frame_clr  in  1  synchronous one-cycle pulse that clears the pixel counter at frame start.
REQ-009 eng_ack  out  NUM_ENG  one-hot grant; at most one bit high in any cycle.
REQ-010 wr_en  out  1  frame-RAM write strobe.
REQ-011 wr_addr  out  19  frame-RAM address, x + y*H_RES.
REQ-012 wr_data  out  8  frame-RAM data.
REQ-013 pix_count  out  19  pixels written since the last clear or wrap.
REQ-014 frame_done  out  1  one-cycle pulse when a full frame has been written.
REQ-015 err_oob  out  1  sticky flag for an out-of-range coordinate.

Function
REQ-016 FSM states SHALL be IDLE, GRANT and WRITE, all registered.
REQ-017 IDLE: if any eng_req bit is high, the block SHALL register the round-robin winner into eng_ack and go to GRANT; otherwise it stays in IDLE.
REQ-018 GRANT: exactly one eng_ack bit SHALL be high for exactly one cycle, eng_word SHALL be captured at the closing edge, and the next state SHALL be WRITE.
REQ-019 WRITE: wr_en SHALL be high for one cycle with the captured wr_addr/wr_data, unless suppressed per REQ-024.
REQ-020 WRITE exit: if any eng_req bit other than the just-served engine's is high, the next state SHALL be GRANT for the next winner; otherwise the next state SHALL be IDLE.
REQ-021 Latency: eng_req sampled in IDLE at cycle N gives eng_ack in N+1 and wr_en in N+2; back-to-back grants are spaced 2 cycles apart.
REQ-022 Round-robin: the search SHALL start at last-served index +1 and wrap from NUM_ENG-1 to 0; the last-served engine SHALL be masked during WRITE.
REQ-023 Address: wr_addr SHALL equal x + (y<<9) + (y<<7), computed at full 19-bit width with no truncation (maximum 307199).
REQ-024 Out of range: if x >= H_RES or y >= V_RES, then wr_en SHALL stay low, err_oob SHALL set, and pix_count SHALL NOT increment; the engine is still acknowledged.
REQ-025 pix_count SHALL increment on every asserted wr_en.
REQ-026 Wrap: the write that brings pix_count to H_RES*V_RES SHALL instead return pix_count to 0 and pulse frame_done in the following cycle.
REQ-027 frame_clr SHALL set pix_count to 0 next cycle and clear err_oob.
REQ-028 frame_clr has priority over a simultaneous write: pix_count SHALL become 0, the write proceeds, the write is not counted, and frame_done SHALL NOT pulse.
REQ-029 Engines deassert eng_req no later than one cycle after their eng_ack; a request still high after its own WRITE SHALL be treated as a new request.
REQ-030 eng_req is ignored during GRANT.

Reset
REQ-031 On iRST_N low, the block SHALL asynchronously force: state IDLE, eng_ack 0, wr_en 0, wr_addr 0, wr_data 0, pix_count 0, frame_done 0, err_oob 0, and last-served pointer NUM_ENG-1 (engine 0 wins first).
REQ-032 Reset asserted mid-GRANT or mid-WRITE SHALL abort the transaction with no wr_en; after release, operation SHALL resume from IDLE on the first rising edge.

Verification
REQ-033 Single request: eng_req=0x001, eng_word x=5, y=2, data=0x3C -> eng_ack=0x001 for 1 cycle, then wr_en with wr_addr=1285, wr_data=0x3C, pix_count=1.
REQ-034 Fairness: all 12 eng_req held high continuously after reset -> grants occur in order 0,1,...,11,0 at a spacing of 2 cycles, with eng_ack never multi-hot.
REQ-035 Corner pixel: x=639, y=479 -> wr_addr=307199; pre-load pix_count to 307199 via writes -> pix_count becomes 0 and frame_done pulses exactly 1 cycle.
REQ-036 Out of range: x=640, y=0 -> eng_ack pulses, wr_en stays 0, err_oob=1, pix_count unchanged; a subsequent frame_clr clears err_oob.
REQ-037 Collision: frame_clr coincident with a WRITE cycle -> wr_en=1 and pix_count=0 next cycle; a mid-GRANT iRST_N pulse -> no wr_en, and engine 0 is granted first after release.
